// File: rtl/decode_mux_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : decode_mux_arb
//  Description : Round-robin merge of N format-decoder channels into one
//                decoded-instruction stream, buffered by an output FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_mux_arb #(
    parameter int numChannels  = 4,
    parameter int chIdWidth    = 2,
    parameter int payloadWidth = 128,
    parameter int majIdWidth   = 64,
    parameter int fifoDepth    = 4,
    parameter int occWidth     = 3
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                flush_i,
    input  logic [numChannels-1:0]              chValid_i,
    output logic [numChannels-1:0]              chReady_o,
    input  logic [numChannels*majIdWidth-1:0]   chMajId_i,
    input  logic [numChannels*payloadWidth-1:0] chPayload_i,
    output logic                                outValid_o,
    input  logic                                outReady_i,
    output logic [chIdWidth-1:0]                outChannel_o,
    output logic [majIdWidth-1:0]               outMajId_o,
    output logic [payloadWidth-1:0]             outPayload_o,
    output logic [occWidth-1:0]                 occupancy_o
);

    localparam int                  c_PTR_W     = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
    localparam int                  c_ENTRY_W   = chIdWidth + majIdWidth + payloadWidth;
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(fifoDepth - 1);
    localparam logic [occWidth-1:0] c_DEPTH     = occWidth'(fifoDepth);
    localparam logic [chIdWidth:0]  c_NUM_EXT   = (chIdWidth + 1)'(numChannels);
    localparam logic [chIdWidth-1:0] c_CH_LAST  = chIdWidth'(numChannels - 1);

    logic [c_ENTRY_W-1:0]   r_mem [fifoDepth];
    logic [c_PTR_W-1:0]     r_wrPtr;
    logic [c_PTR_W-1:0]     r_rdPtr;
    logic [occWidth-1:0]    r_count;
    logic [chIdWidth-1:0]   r_rrPtr;

    logic [majIdWidth-1:0]   w_chMaj [numChannels];
    logic [payloadWidth-1:0] w_chPay [numChannels];
    logic [chIdWidth:0]      w_scan;
    logic                    w_found;
    logic [chIdWidth-1:0]    w_grant;
    logic                    w_pop;
    logic                    w_space;
    logic                    w_push;
    logic [numChannels-1:0]  w_ready;
    logic [c_PTR_W-1:0]      w_wrNext;
    logic [c_PTR_W-1:0]      w_rdNext;
    logic [chIdWidth-1:0]    w_rrNext;

    // Channel 0 occupies the most significant slice of the packed buses.
    generate
        for (genvar k = 0; k < numChannels; k++) begin : g_unpack
            assign w_chMaj[k] = chMajId_i[(numChannels-1-k)*majIdWidth +: majIdWidth];
            assign w_chPay[k] = chPayload_i[(numChannels-1-k)*payloadWidth +: payloadWidth];
        end
    endgenerate

    always_comb begin
        w_scan  = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < numChannels; i++) begin
            w_scan = {1'b0, r_rrPtr} + (chIdWidth + 1)'(i);
            if (w_scan >= c_NUM_EXT) begin
                w_scan = w_scan - c_NUM_EXT;
            end
            if (!w_found && chValid_i[w_scan[chIdWidth-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_scan[chIdWidth-1:0];
            end
        end
    end

    assign outValid_o = (r_count != '0);
    assign w_pop      = outValid_o & outReady_i;
    assign w_space    = (r_count < c_DEPTH) | w_pop;
    // Gating with reset_i keeps every channel stalled while reset is held.
    assign w_push     = w_found & w_space & ~flush_i & reset_i;

    always_comb begin
        w_ready          = '0;
        w_ready[w_grant] = w_push;
    end
    assign chReady_o = w_ready;

    assign w_wrNext = (r_wrPtr == c_PTR_LAST) ? '0 : r_wrPtr + 1'b1;
    assign w_rdNext = (r_rdPtr == c_PTR_LAST) ? '0 : r_rdPtr + 1'b1;
    assign w_rrNext = (w_grant == c_CH_LAST)  ? '0 : w_grant + 1'b1;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_rrPtr <= '0;
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= w_wrNext;
                r_rrPtr <= w_rrNext;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdNext;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {w_grant, w_chMaj[w_grant], w_chPay[w_grant]};
        end
    end

    assign {outChannel_o, outMajId_o, outPayload_o} = r_mem[r_rdPtr];
    assign occupancy_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_mux_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_decode_mux_arb
//  Description : Directed, table-driven bench for decode_mux_arb (4 ch, depth 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_mux_arb;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic [3:0]     ch_valid;
    logic [3:0]     ch_ready;
    logic [255:0]   ch_maj;
    logic [511:0]   ch_pay;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_ch;
    logic [63:0]    out_maj;
    logic [127:0]   out_pay;
    logic [2:0]     occ;

    logic [63:0]    maj_arr [4];
    logic [127:0]   pay_arr [4];

    int n_pass  = 0;
    int n_total = 0;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_pack
            assign ch_maj[(3-k)*64 +: 64]   = maj_arr[k];
            assign ch_pay[(3-k)*128 +: 128] = pay_arr[k];
        end
    endgenerate

    decode_mux_arb #(
        .numChannels(4), .chIdWidth(2), .payloadWidth(128),
        .majIdWidth(64), .fifoDepth(4), .occWidth(3)
    ) dut (
        .clock_i(clk), .reset_i(rst_n), .flush_i(flush),
        .chValid_i(ch_valid), .chReady_o(ch_ready),
        .chMajId_i(ch_maj), .chPayload_i(ch_pay),
        .outValid_o(out_valid), .outReady_i(out_ready),
        .outChannel_o(out_ch), .outMajId_o(out_maj),
        .outPayload_o(out_pay), .occupancy_o(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_vld;
        logic [1:0] exp_ch;
        logic [2:0] exp_occ;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 3'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 3'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 3'd1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 3'd1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 3'd1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 3'd1};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 3'd1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 3'd1};
        tbl[8]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 3'd0};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3, 3'd1};
        tbl[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd2, 3'd1};
        tbl[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 3'd1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 3'd1};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 3'd0};

        for (int k = 0; k < 4; k++) begin
            maj_arr[k] = 64'(k);
            pay_arr[k] = 128'(k);
        end
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; ch_valid = 4'b1111;

        // Reset state, with channels requesting while reset is held
        #12;
        chk("reset_valid", 128'(out_valid), 128'd0);
        chk("reset_occ",   128'(occ),       128'd0);
        chk("reset_ready", 128'(ch_ready),  128'd0);
        ch_valid = 4'b0000;
        rst_n = 1'b1;
        #1;
        chk("release_ready", 128'(ch_ready), 128'd0);
        tick();

        // Round-robin sequence and rrPtr wrap
        for (int i = 0; i < 14; i++) begin
            ch_valid  = tbl[i].valid;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("rr%0d_ready", i), 128'(ch_ready),  128'(tbl[i].exp_ready));
            chk($sformatf("rr%0d_valid", i), 128'(out_valid), 128'(tbl[i].exp_vld));
            chk($sformatf("rr%0d_occ", i),   128'(occ),       128'(tbl[i].exp_occ));
            if (tbl[i].exp_vld) begin
                chk($sformatf("rr%0d_ch", i),  128'(out_ch),  128'(tbl[i].exp_ch));
                chk($sformatf("rr%0d_pay", i), out_pay,       128'(tbl[i].exp_ch));
            end
            tick();
        end

        // Fill to capacity, then simultaneous push and pop at full
        out_ready = 1'b0;
        ch_valid  = 4'b0001;
        for (int p = 'h11; p <= 'h14; p++) begin
            pay_arr[0] = 128'(p);
            #1;
            chk($sformatf("fill_%0h_ready", p), 128'(ch_ready), 128'b0001);
            tick();
        end
        pay_arr[0] = 128'h15;
        #1;
        chk("full_occ",   128'(occ),      128'd4);
        chk("full_ready", 128'(ch_ready), 128'd0);
        chk("full_head",  out_pay,        128'h11);
        out_ready = 1'b1;
        #1;
        chk("pushpop_ready", 128'(ch_ready), 128'b0001);
        tick();
        ch_valid = 4'b0000;
        #1;
        chk("pushpop_occ",  128'(occ), 128'd4);
        chk("pushpop_head", out_pay,   128'h12);
        for (int p = 'h12; p <= 'h15; p++) begin
            #1;
            chk($sformatf("drain_%0h", p), out_pay, 128'(p));
            tick();
        end
        chk("drained_occ", 128'(occ), 128'd0);

        // Flush with three entries held and ch1 requesting
        out_ready = 1'b0;
        ch_valid  = 4'b0001;
        for (int p = 'h31; p <= 'h33; p++) begin
            pay_arr[0] = 128'(p);
            tick();
        end
        ch_valid   = 4'b0010;
        maj_arr[1] = 64'h77;
        pay_arr[1] = 128'h77;
        flush      = 1'b1;
        out_ready  = 1'b1;
        #1;
        chk("flush_occ_before", 128'(occ),      128'd3);
        chk("flush_ready",      128'(ch_ready), 128'd0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_occ",         128'(occ),       128'd0);
        chk("flush_valid",       128'(out_valid), 128'd0);
        chk("postflush_ready",   128'(ch_ready),  128'b0010);
        tick();
        ch_valid = 4'b0000;
        chk("postflush_valid", 128'(out_valid), 128'd1);
        chk("postflush_ch",    128'(out_ch),    128'd1);
        chk("postflush_maj",   128'(out_maj),   128'h77);
        chk("postflush_occ",   128'(occ),       128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: head must hold while other channels fill the FIFO
        ch_valid   = 4'b0001;
        maj_arr[0] = 64'h2A;
        tick();
        ch_valid = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("hold%0d_maj", c), 128'(out_maj), 128'h2A);
            chk($sformatf("hold%0d_occ", c), 128'(occ),     128'((c + 1 > 4) ? 4 : c + 1));
            if (c >= 3) chk($sformatf("hold%0d_ready", c), 128'(ch_ready), 128'd0);
            tick();
        end
        chk("hold_sat_occ", 128'(occ), 128'd4);
        ch_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("hold_drained", 128'(occ), 128'd0);

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        ch_valid  = 4'b0001;
        tick();
        tick();
        ch_valid = 4'b0000;
        #1;
        chk("pre_areset_occ", 128'(occ), 128'd2);
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 128'(out_valid), 128'd0);
        chk("areset_occ",   128'(occ),       128'd0);
        ch_valid = 4'b1111;
        #1;
        chk("areset_ready", 128'(ch_ready), 128'd0);
        ch_valid = 4'b0000;
        rst_n = 1'b1;
        #1;
        chk("arelease_ready", 128'(ch_ready), 128'd0);
        tick();
        chk("arelease_occ",   128'(occ),       128'd0);
        chk("arelease_valid", 128'(out_valid), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
